rstation_append: RTL and testbench
==================================

RSTATION_APPEND -- requirements
Module: rstation_append

Interface
REQ-001 Parameters SHALL be: ENTRIES, default 3, entries per station; DW, default 16, operand field width.
REQ-002 clk1  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 rs1b, rs2b  input  1 each  operand status: 1 = rs1/rs2 carries a ready register value; 0 = rs1/rs2 carries a pending ROB tag.
REQ-005 rs1, rs2  input  4 each  operand value (zero-extended to DW) or ROB tag (low 3 bits).
REQ-006 rob_ind  input  3  destination ROB index of the issued instruction.
REQ-007 func  input  4  opcode: 0000/0001 add unit; 0010/0011 mul unit; 0100/0101 branch unit; all other codes invalid.
REQ-008 rd  input  4  destination architectural register.
REQ-009 count  input  1  issue-valid strobe; 1 = append this instruction.
REQ-010 cdb_valid, cdb_tag[2:0], cdb_value[DW-1:0]  input  result broadcast used to wake pending operands.
REQ-011 free_valid, free_unit[1:0] (0 add, 1 mul, 2 branch), free_idx[1:0]  input  releases one entry.
REQ-012 rd_unit[1:0], rd_idx[1:0]  input  combinational read-port select.
REQ-013 accept, reject  output  1 each  registered one-cycle pulses reporting the previous cycle's append outcome.
REQ-014 add_count, mul_count, bch_count  output  2 each  occupied entries per station.
REQ-015 add_ready, mul_ready, bch_ready  output  ENTRIES each  per-entry flag: valid and both operands ready.
REQ-016 rd_valid, rd_func[3:0], rd_rd[3:0], rd_rob[2:0], rd_v1[DW-1:0], rd_v2[DW-1:0], rd_p1, rd_p2  output  contents of the selected entry; rd_p1/rd_p2 = 1 while the operand is pending.

Function
REQ-017 Each station SHALL hold ENTRIES entries with fields valid, func, rd, rob, p1, v1, p2, v2.
REQ-018 When count=1 and func is valid, the instruction SHALL be written into the lowest-index non-valid entry of its station, judged on state at the start of the cycle.
REQ-019 Source fields on append SHALL be: p = ~rsNb; v = zero-extended rsN.
REQ-020 Bypass on append: when cdb_valid=1, an operand is pending, and its tag equals cdb_tag, the operand SHALL be stored ready (p=0) with v = cdb_value.
REQ-021 Every cycle, every valid entry with p=1 and tag matching cdb_tag while cdb_valid=1 SHALL set p=0 and v = cdb_value.
REQ-022 free_valid=1 SHALL clear valid of the addressed entry; freeing an empty or out-of-range entry SHALL have no effect.
REQ-023 A slot freed in cycle N SHALL NOT be reused by an append in cycle N; it is available from cycle N+1.
REQ-024 Counts SHALL equal the number of valid entries per station, updated the cycle after append or free; an append and a free in the same cycle on one station SHALL leave the count unchanged.
REQ-025 If count=1 and the target station is full, or func is invalid, no state SHALL change apart from reject=1 in the next cycle.
REQ-026 accept SHALL be 1 in the cycle after a successful append; accept and reject SHALL never both be 1.
REQ-027 Ready flags SHALL be derived combinationally from the registered entry state.
REQ-028 Read-port outputs SHALL be combinational; an out-of-range select SHALL drive all read-port outputs to 0.

Reset
REQ-029 On rst=1 at a clock edge, all entries SHALL be cleared to valid=0 with all fields 0, all counts 0, accept=0, reject=0.
REQ-030 rst SHALL take priority over a simultaneous append, free or CDB event.

Verification
REQ-031 Reset, then append func=0000, rs1b=1, rs1=5, rs2b=1, rs2=3, rob_ind=2, rd=4 -> next cycle: accept=1, add_count=1, add_ready=001; reading add entry 0 gives v1=5, v2=3, rob=2.
REQ-032 Append func=0010 with rs1b=0, rs1=6 (tag), then cdb_valid=1, cdb_tag=6, cdb_value=0x00AB -> mul entry 0 shows p1=0, v1=0x00AB and its ready bit sets.
REQ-033 Four appends of func=0001 -> first three give accept with add_count reaching 3; the fourth gives reject=1 and the count stays at 3.
REQ-034 With add full, free_unit=0, free_idx=1 in the same cycle as an add append -> that append is rejected; an append in the next cycle fills entry 1.
REQ-035 Append with pending tag 3 while cdb_valid=1, cdb_tag=3, cdb_value=7 in the same cycle -> the entry is stored ready with v=7.
REQ-036 Assert rst with all three stations partly filled -> every count is 0, every ready flag is 0, and rd_valid=0 for every select.

Source files
------------

// File: rtl/rstation_append.sv
// Reservation stations (add / mul / branch) with issue append, CDB wakeup,
// entry release and a combinational read port.
module rstation_append #(
    parameter int ENTRIES = 3,
    parameter int DW      = 16
) (
    input  logic               clk1,
    input  logic               rst,
    input  logic               rs1b,
    input  logic               rs2b,
    input  logic [3:0]         rs1,
    input  logic [3:0]         rs2,
    input  logic [2:0]         rob_ind,
    input  logic [3:0]         func,
    input  logic [3:0]         rd,
    input  logic               count,
    input  logic               cdb_valid,
    input  logic [2:0]         cdb_tag,
    input  logic [DW-1:0]      cdb_value,
    input  logic               free_valid,
    input  logic [1:0]         free_unit,
    input  logic [1:0]         free_idx,
    input  logic [1:0]         rd_unit,
    input  logic [1:0]         rd_idx,
    output logic               accept,
    output logic               reject,
    output logic [1:0]         add_count,
    output logic [1:0]         mul_count,
    output logic [1:0]         bch_count,
    output logic [ENTRIES-1:0] add_ready,
    output logic [ENTRIES-1:0] mul_ready,
    output logic [ENTRIES-1:0] bch_ready,
    output logic               rd_valid,
    output logic [3:0]         rd_func,
    output logic [3:0]         rd_rd,
    output logic [2:0]         rd_rob,
    output logic [DW-1:0]      rd_v1,
    output logic [DW-1:0]      rd_v2,
    output logic               rd_p1,
    output logic               rd_p2
);
    localparam int NU = 3;

    logic          valid_q [NU][ENTRIES];
    logic          valid_d [NU][ENTRIES];
    logic [3:0]    func_q  [NU][ENTRIES];
    logic [3:0]    func_d  [NU][ENTRIES];
    logic [3:0]    rd_q    [NU][ENTRIES];
    logic [3:0]    rd_d    [NU][ENTRIES];
    logic [2:0]    rob_q   [NU][ENTRIES];
    logic [2:0]    rob_d   [NU][ENTRIES];
    logic          p1_q    [NU][ENTRIES];
    logic          p1_d    [NU][ENTRIES];
    logic          p2_q    [NU][ENTRIES];
    logic          p2_d    [NU][ENTRIES];
    logic [DW-1:0] v1_q    [NU][ENTRIES];
    logic [DW-1:0] v1_d    [NU][ENTRIES];
    logic [DW-1:0] v2_q    [NU][ENTRIES];
    logic [DW-1:0] v2_d    [NU][ENTRIES];
    logic          accept_q, accept_d;
    logic          reject_q, reject_d;

    logic [1:0]    unit;
    logic          func_ok;
    logic          placed;
    logic [1:0]    cnt [NU];

    always_comb begin
        valid_d  = valid_q;
        func_d   = func_q;
        rd_d     = rd_q;
        rob_d    = rob_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        v1_d     = v1_q;
        v2_d     = v2_q;
        unit     = func[2:1];
        func_ok  = (func < 4'd6);
        placed   = 1'b0;
        // Append target is judged on valid_q, so a slot freed now stays empty
        for (int u = 0; u < NU; u++) begin
            for (int e = 0; e < ENTRIES; e++) begin
                if (cdb_valid && valid_q[u][e]) begin
                    if (p1_q[u][e] && v1_q[u][e][2:0] == cdb_tag) begin
                        p1_d[u][e] = 1'b0;
                        v1_d[u][e] = cdb_value;
                    end
                    if (p2_q[u][e] && v2_q[u][e][2:0] == cdb_tag) begin
                        p2_d[u][e] = 1'b0;
                        v2_d[u][e] = cdb_value;
                    end
                end
                if (free_valid && free_unit == 2'(u) &&
                    free_idx == 2'(e) && valid_q[u][e]) begin
                    valid_d[u][e] = 1'b0;
                end
                if (count && func_ok && !placed &&
                    unit == 2'(u) && !valid_q[u][e]) begin
                    placed        = 1'b1;
                    valid_d[u][e] = 1'b1;
                    func_d[u][e]  = func;
                    rd_d[u][e]    = rd;
                    rob_d[u][e]   = rob_ind;
                    p1_d[u][e]    = ~rs1b;
                    v1_d[u][e]    = DW'(rs1);
                    p2_d[u][e]    = ~rs2b;
                    v2_d[u][e]    = DW'(rs2);
                    if (!rs1b && cdb_valid && rs1[2:0] == cdb_tag) begin
                        p1_d[u][e] = 1'b0;
                        v1_d[u][e] = cdb_value;
                    end
                    if (!rs2b && cdb_valid && rs2[2:0] == cdb_tag) begin
                        p2_d[u][e] = 1'b0;
                        v2_d[u][e] = cdb_value;
                    end
                end
            end
        end
        accept_d = placed;
        reject_d = count && !placed;
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            for (int u = 0; u < NU; u++) begin
                for (int e = 0; e < ENTRIES; e++) begin
                    valid_q[u][e] <= 1'b0;
                    func_q[u][e]  <= '0;
                    rd_q[u][e]    <= '0;
                    rob_q[u][e]   <= '0;
                    p1_q[u][e]    <= 1'b0;
                    p2_q[u][e]    <= 1'b0;
                    v1_q[u][e]    <= '0;
                    v2_q[u][e]    <= '0;
                end
            end
            accept_q <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            func_q   <= func_d;
            rd_q     <= rd_d;
            rob_q    <= rob_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            accept_q <= accept_d;
            reject_q <= reject_d;
        end
    end

    assign accept = accept_q;
    assign reject = reject_q;

    always_comb begin
        for (int u = 0; u < NU; u++) begin
            cnt[u] = '0;
            for (int e = 0; e < ENTRIES; e++) begin
                cnt[u] = cnt[u] + 2'(valid_q[u][e]);
            end
        end
    end

    assign add_count = cnt[0];
    assign mul_count = cnt[1];
    assign bch_count = cnt[2];

    always_comb begin
        for (int e = 0; e < ENTRIES; e++) begin
            add_ready[e] = valid_q[0][e] & ~p1_q[0][e] & ~p2_q[0][e];
            mul_ready[e] = valid_q[1][e] & ~p1_q[1][e] & ~p2_q[1][e];
            bch_ready[e] = valid_q[2][e] & ~p1_q[2][e] & ~p2_q[2][e];
        end
    end

    // Unit 3 or an index past ENTRIES never matches, leaving all zeros
    always_comb begin
        rd_valid = 1'b0;
        rd_func  = '0;
        rd_rd    = '0;
        rd_rob   = '0;
        rd_v1    = '0;
        rd_v2    = '0;
        rd_p1    = 1'b0;
        rd_p2    = 1'b0;
        for (int u = 0; u < NU; u++) begin
            for (int e = 0; e < ENTRIES; e++) begin
                if (rd_unit == 2'(u) && rd_idx == 2'(e)) begin
                    rd_valid = valid_q[u][e];
                    rd_func  = func_q[u][e];
                    rd_rd    = rd_q[u][e];
                    rd_rob   = rob_q[u][e];
                    rd_v1    = v1_q[u][e];
                    rd_v2    = v2_q[u][e];
                    rd_p1    = p1_q[u][e];
                    rd_p2    = p2_q[u][e];
                end
            end
        end
    end
endmodule

// File: tb/tb_rstation_append.sv
// Scoreboard bench for rstation_append: directed scenarios plus random
// traffic checked against a behavioural station model.
module tb_rstation_append;
    localparam int ENT = 3;
    localparam int DW  = 16;

    logic           clk1 = 1'b0;
    logic           rst = 1'b1;
    logic           rs1b = 1'b0, rs2b = 1'b0;
    logic [3:0]     rs1 = '0, rs2 = '0;
    logic [2:0]     rob_ind = '0;
    logic [3:0]     func = '0;
    logic [3:0]     rd = '0;
    logic           count = 1'b0;
    logic           cdb_valid = 1'b0;
    logic [2:0]     cdb_tag = '0;
    logic [DW-1:0]  cdb_value = '0;
    logic           free_valid = 1'b0;
    logic [1:0]     free_unit = '0, free_idx = '0;
    logic [1:0]     rd_unit = '0, rd_idx = '0;
    logic           accept, reject;
    logic [1:0]     add_count, mul_count, bch_count;
    logic [ENT-1:0] add_ready, mul_ready, bch_ready;
    logic           rd_valid;
    logic [3:0]     rd_func, rd_rd;
    logic [2:0]     rd_rob;
    logic [DW-1:0]  rd_v1, rd_v2;
    logic           rd_p1, rd_p2;

    rstation_append #(.ENTRIES(ENT), .DW(DW)) dut (
        .clk1(clk1), .rst(rst),
        .rs1b(rs1b), .rs2b(rs2b), .rs1(rs1), .rs2(rs2),
        .rob_ind(rob_ind), .func(func), .rd(rd), .count(count),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .free_valid(free_valid), .free_unit(free_unit), .free_idx(free_idx),
        .rd_unit(rd_unit), .rd_idx(rd_idx),
        .accept(accept), .reject(reject),
        .add_count(add_count), .mul_count(mul_count), .bch_count(bch_count),
        .add_ready(add_ready), .mul_ready(mul_ready), .bch_ready(bch_ready),
        .rd_valid(rd_valid), .rd_func(rd_func), .rd_rd(rd_rd),
        .rd_rob(rd_rob), .rd_v1(rd_v1), .rd_v2(rd_v2),
        .rd_p1(rd_p1), .rd_p2(rd_p2)
    );

    always #50 clk1 = ~clk1;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    // Model: per station, per slot record of what an instruction holds
    logic          m_valid [3][ENT];
    logic [3:0]    m_func  [3][ENT];
    logic [3:0]    m_rd    [3][ENT];
    logic [2:0]    m_rob   [3][ENT];
    logic          m_p1    [3][ENT];
    logic          m_p2    [3][ENT];
    logic [DW-1:0] m_v1    [3][ENT];
    logic [DW-1:0] m_v2    [3][ENT];

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endfunction

    function automatic void model_clear();
        for (int u = 0; u < 3; u++)
            for (int e = 0; e < ENT; e++) begin
                m_valid[u][e] = 0; m_func[u][e] = 0; m_rd[u][e] = 0;
                m_rob[u][e] = 0; m_p1[u][e] = 0; m_p2[u][e] = 0;
                m_v1[u][e] = 0; m_v2[u][e] = 0;
            end
    endfunction

    function automatic void model_step();
        logic was [3][ENT];
        int fu, fi, u, slot;
        if (rst) begin
            model_clear();
            return;
        end
        was = m_valid;
        if (cdb_valid)
            for (int a = 0; a < 3; a++)
                for (int e = 0; e < ENT; e++)
                    if (m_valid[a][e]) begin
                        if (m_p1[a][e] && m_v1[a][e][2:0] == cdb_tag) begin
                            m_p1[a][e] = 0; m_v1[a][e] = cdb_value;
                        end
                        if (m_p2[a][e] && m_v2[a][e][2:0] == cdb_tag) begin
                            m_p2[a][e] = 0; m_v2[a][e] = cdb_value;
                        end
                    end
        fu = int'(free_unit);
        fi = int'(free_idx);
        if (free_valid && fu < 3 && fi < ENT) m_valid[fu][fi] = 0;
        if (count) begin
            slot = -1;
            if (int'(func) <= 5) begin
                u = int'(func) / 2;
                for (int e = ENT - 1; e >= 0; e--)
                    if (!was[u][e]) slot = e;
            end
            if (slot >= 0) begin
                m_valid[u][slot] = 1; m_func[u][slot] = func;
                m_rd[u][slot] = rd; m_rob[u][slot] = rob_ind;
                m_p1[u][slot] = !rs1b; m_v1[u][slot] = DW'(rs1);
                m_p2[u][slot] = !rs2b; m_v2[u][slot] = DW'(rs2);
                if (!rs1b && cdb_valid && rs1[2:0] == cdb_tag) begin
                    m_p1[u][slot] = 0; m_v1[u][slot] = cdb_value;
                end
                if (!rs2b && cdb_valid && rs2[2:0] == cdb_tag) begin
                    m_p2[u][slot] = 0; m_v2[u][slot] = cdb_value;
                end
                exp_q.push_back(1'b1);
            end else begin
                exp_q.push_back(1'b0);
            end
        end
    endfunction

    task automatic check_state();
        logic [1:0]     dc  [3];
        logic [ENT-1:0] drdy[3];
        logic [45:0]    exp_rd;
        int n;
        logic [ENT-1:0] rdy;
        dc   = '{add_count, mul_count, bch_count};
        drdy = '{add_ready, mul_ready, bch_ready};
        for (int u = 0; u < 3; u++) begin
            n = 0;
            rdy = '0;
            for (int e = 0; e < ENT; e++) begin
                n += int'(m_valid[u][e]);
                rdy[e] = m_valid[u][e] && !m_p1[u][e] && !m_p2[u][e];
            end
            chk($sformatf("count_u%0d", u), 64'(dc[u]), 64'(n));
            chk($sformatf("ready_u%0d", u), 64'(drdy[u]), 64'(rdy));
        end
        for (int u = 0; u < 4; u++)
            for (int e = 0; e < 4; e++) begin
                rd_unit = 2'(u);
                rd_idx  = 2'(e);
                #1;
                exp_rd = '0;
                if (u < 3 && e < ENT)
                    exp_rd = {m_valid[u][e], m_func[u][e], m_rd[u][e],
                              m_rob[u][e], m_v1[u][e], m_v2[u][e],
                              m_p1[u][e], m_p2[u][e]};
                chk($sformatf("read_u%0d_i%0d", u, e),
                    64'({rd_valid, rd_func, rd_rd, rd_rob,
                         rd_v1, rd_v2, rd_p1, rd_p2}), 64'(exp_rd));
            end
    endtask

    task automatic step();
        model_step();
        @(negedge clk1);
        rst = 0; count = 0; cdb_valid = 0; free_valid = 0;
        check_state();
    endtask

    task automatic app(input logic [3:0] f, input logic b1, input logic [3:0] a1,
                       input logic b2, input logic [3:0] a2,
                       input logic [2:0] rob, input logic [3:0] dst);
        count = 1; func = f; rs1b = b1; rs1 = a1; rs2b = b2; rs2 = a2;
        rob_ind = rob; rd = dst;
    endtask

    task automatic sel(input logic [1:0] u, input logic [1:0] i);
        rd_unit = u; rd_idx = i;
        #1;
    endtask

    // Monitor: every accept/reject pulse is matched against the scoreboard
    initial begin
        forever begin
            @(negedge clk1);
            checks++;
            if (accept && reject) begin
                errors++;
                $display("FAIL accept_reject_both actual=11 expected=not_both");
            end
            if (accept || reject) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp actual=acc%0d_rej%0d expected=none",
                             accept, reject);
                end else begin
                    chk("resp_accept", 64'(accept), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        model_clear();
        rst = 1;
        step();
        chk("reset_accept", 64'(accept), 0);
        chk("reset_reject", 64'(reject), 0);

        app(4'd0, 1, 4'd5, 1, 4'd3, 3'd2, 4'd4);
        step();
        chk("r31_accept", 64'(accept), 1);
        chk("r31_add_count", 64'(add_count), 1);
        chk("r31_add_ready", 64'(add_ready), 64'b001);
        sel(2'd0, 2'd0);
        chk("r31_v1", 64'(rd_v1), 5);
        chk("r31_v2", 64'(rd_v2), 3);
        chk("r31_rob", 64'(rd_rob), 2);

        app(4'd2, 0, 4'd6, 1, 4'd1, 3'd1, 4'd2);
        step();
        chk("r32_pending_ready", 64'(mul_ready[0]), 0);
        cdb_valid = 1; cdb_tag = 3'd6; cdb_value = 16'h00AB;
        step();
        sel(2'd1, 2'd0);
        chk("r32_p1", 64'(rd_p1), 0);
        chk("r32_v1", 64'(rd_v1), 64'h00AB);
        chk("r32_ready", 64'(mul_ready[0]), 1);

        rst = 1;
        step();
        for (int k = 0; k < 4; k++) begin
            app(4'd1, 1, 4'(k), 1, 4'd1, 3'(k), 4'(k + 1));
            step();
            if (k == 2) chk("r33_count3", 64'(add_count), 3);
        end
        chk("r33_reject", 64'(reject), 1);
        chk("r33_count_stays", 64'(add_count), 3);

        app(4'd0, 1, 4'd2, 1, 4'd2, 3'd5, 4'd7);
        free_valid = 1; free_unit = 2'd0; free_idx = 2'd1;
        step();
        chk("r34_reject", 64'(reject), 1);
        chk("r34_count_after_free", 64'(add_count), 2);
        app(4'd0, 1, 4'd2, 1, 4'd2, 3'd5, 4'd9);
        step();
        chk("r34_accept", 64'(accept), 1);
        sel(2'd0, 2'd1);
        chk("r34_slot1_rd", 64'({rd_valid, rd_rd}), 64'h19);

        rst = 1;
        step();
        app(4'd4, 0, 4'd3, 1, 4'd2, 3'd0, 4'd1);
        cdb_valid = 1; cdb_tag = 3'd3; cdb_value = 16'd7;
        step();
        sel(2'd2, 2'd0);
        chk("r35_p1", 64'(rd_p1), 0);
        chk("r35_v1", 64'(rd_v1), 7);
        chk("r35_ready", 64'(bch_ready), 64'b001);

        for (int k = 0; k < 5; k++) begin
            app(4'(k), 1, 4'(k), 0, 4'(k), 3'(k), 4'(k));
            step();
        end
        app(4'd0, 1, 4'd1, 1, 4'd1, 3'd1, 4'd1);
        free_valid = 1; free_unit = 2'd2; free_idx = 2'd0;
        cdb_valid = 1; cdb_tag = 3'd1;
        rst = 1;
        step();
        chk("r36_counts", 64'({add_count, mul_count, bch_count}), 0);
        chk("r36_ready", 64'({add_ready, mul_ready, bch_ready}), 0);
        chk("r36_accept", 64'({accept, reject}), 0);

        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            count = ($urandom_range(0, 2) != 0);
            func = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(6, 15))
                                               : 4'($urandom_range(0, 5));
            rs1b = 1'($urandom_range(0, 1));
            rs2b = 1'($urandom_range(0, 1));
            rs1 = 4'($urandom); rs2 = 4'($urandom);
            rob_ind = 3'($urandom); rd = 4'($urandom);
            cdb_valid = 1'($urandom_range(0, 1));
            cdb_tag = 3'($urandom); cdb_value = 16'($urandom);
            free_valid = ($urandom_range(0, 2) == 0);
            free_unit = 2'($urandom); free_idx = 2'($urandom);
            step();
        end

        step();
        step();
        chk("resp_queue_drained", 64'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
